// File: rtl/lane_serializer.sv
// lane_serializer: splits one LANES*LANE_W word into LANES beats on a
// valid/ready lane stream, flagging the final lane of each word.
// Optional feature macro: LANE_SERIALIZER_BACK2BACK_EN
//   defined   -> a new word may be accepted on the cycle the last lane leaves
//   undefined -> words are accepted only in IDLE (one bubble per word)
module lane_serializer #(
  parameter int LANES     = 4,
  parameter int LANE_W    = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W-1:0]       out_data,
  output logic                    out_last
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(LANES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LANES*LANE_W-1:0] word_q, word_d;

  // Held word rearranged into transmit order: lanes[k] is the k-th beat.
  logic [LANE_W-1:0] lanes [LANES];

  genvar gi;
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      for (gi = 0; gi < LANES; gi++) begin : g_lane
        assign lanes[gi] = word_q[(LANES-1-gi)*LANE_W +: LANE_W];
      end
    end else begin : g_lsb_first
      for (gi = 0; gi < LANES; gi++) begin : g_lane
        assign lanes[gi] = word_q[gi*LANE_W +: LANE_W];
      end
    end
  endgenerate

  // A single-lane word needs no counter-driven mux.
  generate
    case (LANES)
      1: begin : g_sel_single
        assign out_data = lanes[0];
      end
      default: begin : g_sel_multi
        assign out_data = lanes[cnt_q];
      end
    endcase
  endgenerate

  assign out_last = (state_q == SEND) && (cnt_q == LAST_CNT);

  // Next-state, lane counter, word capture and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
`ifdef LANE_SERIALIZER_BACK2BACK_EN
            // Refill in the same cycle the final lane is consumed.
            in_ready = 1'b1;
            if (in_valid) begin
              word_d  = in_data;
              cnt_d   = '0;
              state_d = SEND;
            end
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and held word registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: three instances (LSB-first x4, MSB-first x4,
// single lane) share one stimulus stream; each is checked every cycle
// against a beats-remaining model of the word it is sending.
module tb_lane_serializer;

`ifdef LANE_SERIALIZER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic       rdy [3];
  logic       ov  [3];
  logic       ol  [3];
  logic [7:0] od  [3];

  always #5 clk = ~clk;

  lane_serializer #(.LANES(4), .LANE_W(8), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_last(ol[0]));

  lane_serializer #(.LANES(4), .LANE_W(8), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_last(ol[1]));

  lane_serializer #(.LANES(1), .LANE_W(8), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_data(in_data[7:0]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_last(ol[2]));

  // Model: each instance is either idle or owes m_rem more beats of m_word,
  // the next being beat number m_pos of the word.
  int          lanes_of [3] = '{4, 4, 1};
  int          msb_of   [3] = '{0, 1, 0};
  int          m_rem    [3];
  int          m_pos    [3];
  int          m_acc    [3];
  logic [31:0] m_word   [3];
  bit          known    = 1'b0;
  bit          rst_prev = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int beat_cnt    = 0;
  int first_cyc   = 0;
  int last_cyc    = 0;

  function automatic logic exp_ready(int d, logic ordy);
    return (m_rem[d] == 0) || (B2B && m_rem[d] == 1 && ordy);
  endfunction

  function automatic logic [7:0] exp_data(int d);
    int idx;
    idx = (msb_of[d] != 0) ? (lanes_of[d] - 1 - m_pos[d]) : m_pos[d];
    return 8'((m_word[d] >> (8 * idx)) & 32'hFF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // One clock: apply inputs, check every instance, advance the model.
  task automatic step(input logic r, input logic iv, input logic [31:0] din, input logic ordy);
    logic er [3];
    rst = r; in_valid = iv; in_data = din; out_ready = ordy;
    #1;
    for (int d = 0; d < 3; d++) begin
      er[d] = exp_ready(d, ordy);
      if (known) begin
        chk($sformatf("dut%0d.out_valid", d), 32'(ov[d]), 32'(m_rem[d] > 0));
        chk($sformatf("dut%0d.out_last", d), 32'(ol[d]), 32'(m_rem[d] == 1));
        chk($sformatf("dut%0d.in_ready", d), 32'(rdy[d]), 32'(er[d]));
        if (m_rem[d] > 0)
          chk($sformatf("dut%0d.out_data", d), 32'(od[d]), 32'(exp_data(d)));
        else if (rst_prev)
          chk($sformatf("dut%0d.out_data_rst", d), 32'(od[d]), 32'h0);
      end
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        m_rem[d] = 0;
        m_pos[d] = 0;
      end else begin
        if (m_rem[d] > 0 && ordy) begin
          $display("t=%0d dut%0d beat data=%h last=%0d", cyc, d, exp_data(d), m_rem[d] == 1);
          if (d == 0) begin
            if (beat_cnt == 0) first_cyc = cyc;
            beat_cnt++;
            if (beat_cnt == 8) last_cyc = cyc;
          end
          m_rem[d]--;
          m_pos[d]++;
        end
        if (iv && er[d]) begin
          $display("t=%0d dut%0d accept word=%h", cyc, d, din);
          m_word[d] = din;
          m_rem[d]  = lanes_of[d];
          m_pos[d]  = 0;
          m_acc[d]++;
        end
      end
    end
    if (r) known = 1'b1;
    rst_prev = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((m_rem[0] > 0 || m_rem[1] > 0 || m_rem[2] > 0) && g < 40) begin
      step(1'b0, 1'b0, $urandom, 1'b1);
      g++;
    end
    if (g >= 40) timeout(tag);
  endtask

  initial begin
    int g;
    for (int d = 0; d < 3; d++) begin
      m_rem[d] = 0; m_pos[d] = 0; m_acc[d] = 0; m_word[d] = '0;
    end
    @(negedge clk);

    // Reset for two cycles, then the idle post-reset state.
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset.in_ready", 32'(rdy[0]), 32'h1);
    chk("reset.out_valid", 32'(ov[0]), 32'h0);

    // Plain word, full-speed consumer.
    step(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1);
    chk("order.lsb_first", 32'(od[0]), 32'hAA);
    chk("order.msb_first", 32'(od[1]), 32'hDD);
    chk("single.data", 32'(od[2]), 32'hAA);
    chk("single.last", 32'(ol[2]), 32'h1);
    drain("drain.plain");

    // Backpressure while the second lane is presented.
    step(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1);
    step(1'b0, 1'b0, $urandom, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, $urandom, 1'b0);
      chk("stall.hold", 32'(od[0]), 32'hBB);
    end
    drain("drain.stall");

    // Two words offered back to back.
    beat_cnt = 0;
    for (int d = 0; d < 3; d++) m_acc[d] = 0;
    step(1'b0, 1'b1, 32'h03020100, 1'b1);
    g = 0;
    while (m_acc[0] < 2 && g < 20) begin
      step(1'b0, 1'b1, 32'h07060504, 1'b1);
      g++;
    end
    if (g >= 20) timeout("b2b.accept");
    drain("drain.b2b");
    chk("b2b.beats", 32'(beat_cnt), 32'd8);
    chk("b2b.span", 32'(last_cyc - first_cyc + 1), B2B ? 32'd8 : 32'd9);

    // Reset in the middle of a word.
    step(1'b0, 1'b1, 32'hDDCCBBAA, 1'b1);
    g = 0;
    while (!(m_rem[0] > 0 && m_pos[0] == 2) && g < 10) begin
      step(1'b0, 1'b0, $urandom, 1'b1);
      g++;
    end
    if (g >= 10) timeout("midrst.reach");
    chk("midrst.lane_cc", 32'(od[0]), 32'hCC);
    step(1'b1, 1'b0, $urandom, 1'b1);
    chk("midrst.out_valid", 32'(ov[0]), 32'h0);
    chk("midrst.in_ready", 32'(rdy[0]), 32'h1);
    step(1'b0, 1'b1, 32'h44332211, 1'b1);
    chk("midrst.first_lane", 32'(od[0]), 32'h11);
    drain("drain.midrst");

    // Single-lane instance: one beat then idle.
    step(1'b0, 1'b1, 32'h0000005A, 1'b1);
    chk("single.beat", 32'(od[2]), 32'h5A);
    chk("single.beat_last", 32'(ol[2]), 32'h1);
    step(1'b0, 1'b0, $urandom, 1'b1);
    chk("single.idle", 32'(ov[2]), 32'h0);
    drain("drain.single");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 3) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
